// File: rtl/program_loader.sv
// UART boot loader: receives an A5-framed, XOR-checked program image
// and writes 24-bit words into instruction memory while holding the CPU.
module program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [23:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int TW = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    logic [1:0]    rx_sync;
    logic          rx_s;
    logic          rx_prev;
    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_valid;
    logic          rx_err;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    len_q;
    logic [7:0]    word_cnt;
    logic [1:0]    byte_sel;
    logic [15:0]   word_buf;
    logic [7:0]    chk;
    logic [TW-1:0] to_cnt;
    logic          loading;
    logic          strobe;
    logic          timeout;
    logic          last_word;

    assign rx_s = rx_sync[1];

    // Receiver: mid-bit sampling, start bit re-checked to reject glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], uart_rx};
            rx_prev  <= rx_s;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            unique case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_valid <= rx_s;
                        rx_err   <= !rx_s;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign loading   = (state == S_LEN) || (state == S_DATA)
                    || (state == S_CHECK);
    assign strobe    = rx_valid || rx_err;
    assign timeout   = loading && (to_cnt == TO_LAST);
    assign last_word = (word_cnt == len_q - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A byte strobe is always examined before the timeout
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (rx_valid && rx_shift == 8'hA5) begin
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_err) begin
                    state_nxt = S_ERROR;
                end else if (rx_valid) begin
                    state_nxt = S_DATA;
                end else if (timeout) begin
                    state_nxt = S_ERROR;
                end
            end
            S_DATA: begin
                if (rx_err) begin
                    state_nxt = S_ERROR;
                end else if (rx_valid) begin
                    if (byte_sel == 2'd2 && last_word) begin
                        state_nxt = S_CHECK;
                    end
                end else if (timeout) begin
                    state_nxt = S_ERROR;
                end
            end
            S_CHECK: begin
                if (rx_err) begin
                    state_nxt = S_ERROR;
                end else if (rx_valid) begin
                    state_nxt = (rx_shift == chk) ? S_DONE : S_ERROR;
                end else if (timeout) begin
                    state_nxt = S_ERROR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_hold = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        unique case (state)
            S_LEN, S_DATA, S_CHECK: begin
                cpu_hold = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: done = 1'b1;
            S_ERROR: begin
                cpu_hold = 1'b1;
                error    = 1'b1;
            end
            default: ;
        endcase
    end

    // Address advances after the write cycle so it is stable under mem_we
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            len_q     <= '0;
            word_cnt  <= '0;
            byte_sel  <= '0;
            word_buf  <= '0;
            chk       <= '0;
            to_cnt    <= '0;
        end else begin
            mem_we <= 1'b0;
            if (mem_we) begin
                mem_addr <= mem_addr + 8'd1;
            end
            if (!loading || strobe) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (rx_valid) begin
                unique case (state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (rx_shift == 8'hA5) begin
                            word_cnt <= '0;
                            mem_addr <= '0;
                            chk      <= '0;
                            byte_sel <= '0;
                        end
                    end
                    S_LEN: len_q <= rx_shift;
                    S_DATA: begin
                        chk <= chk ^ rx_shift;
                        if (byte_sel == 2'd2) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {word_buf, rx_shift};
                            byte_sel  <= '0;
                            word_cnt  <= word_cnt + 8'd1;
                        end else begin
                            word_buf <= {word_buf[7:0], rx_shift};
                            byte_sel <= byte_sel + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: UART frame driver plus a
// write scoreboard fed by the frame builder and drained on mem_we.
module tb_program_loader;

    localparam int CPB = 4;
    localparam int TO  = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    logic prev_we = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    program_loader #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (mem_we === 1'b1) begin
            we_cnt++;
            check("we_width", 32'(prev_we), 32'd0);
            if (exp_q.size() == 0) begin
                check("we_unexp", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("we_addr", 32'(mem_addr), 32'(e[31:24]));
                check("we_data", 32'(mem_wdata), 32'(e[23:0]));
            end
        end
        prev_we = mem_we;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] len_b,
                              input logic [7:0] pl[$],
                              input bit bad, input bit glitch);
        logic [7:0] c;
        int nw;
        c  = 8'h00;
        nw = pl.size() / 3;
        send_byte(8'hA5, 1'b1);
        check("a5_err_clr", 32'(error), 32'd0);
        check("a5_busy", 32'(busy), 32'd1);
        send_byte(len_b, 1'b1);
        check("len_hold", 32'(cpu_hold), 32'd1);
        if (glitch) begin
            uart_rx = 1'b0;
            repeat (2) @(negedge clk);
            uart_rx = 1'b1;
            repeat (CPB * 12) @(negedge clk);
        end
        for (int w = 0; w < nw; w++) begin
            exp_q.push_back({8'(w), pl[3*w], pl[3*w+1], pl[3*w+2]});
            for (int k = 0; k < 3; k++) begin
                c = c ^ pl[3*w+k];
                send_byte(pl[3*w+k], 1'b1);
            end
        end
        send_byte(bad ? (c ^ 8'h01) : c, 1'b1);
    endtask

    task automatic check_end(input string tag, input logic d,
                             input logic e, input logic h);
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_error"}, 32'(error), 32'(e));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(h));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_qempty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        logic [7:0] fixed[$];
        logic [7:0] pl[$];
        int we0;

        fixed = {8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};

        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send_byte(8'h00, 1'b1);
        send_byte(8'h7F, 1'b1);
        check_end("noise", 1'b0, 1'b0, 1'b0);

        send_frame(8'd2, fixed, 1'b0, 1'b1);
        check_end("good", 1'b1, 1'b0, 1'b0);

        we0 = we_cnt;
        send_frame(8'd2, fixed, 1'b1, 1'b0);
        check_end("badchk", 1'b0, 1'b1, 1'b1);
        check("badchk_writes", 32'(we_cnt - we0), 32'd2);

        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_frame(8'd3, pl, 1'b0, 1'b0);
        check_end("recover", 1'b1, 1'b0, 1'b0);

        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        repeat (250) @(negedge clk);
        check_end("stall", 1'b0, 1'b1, 1'b1);

        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        repeat (4) @(negedge clk);
        check_end("frame", 1'b0, 1'b1, 1'b1);

        pl.delete();
        for (int i = 0; i < 768; i++) pl.push_back(8'($urandom_range(0, 255)));
        we0 = we_cnt;
        send_frame(8'd0, pl, 1'b0, 1'b0);
        check_end("len0", 1'b1, 1'b0, 1'b0);
        check("len0_writes", 32'(we_cnt - we0), 32'd256);
        check("len0_wrap", 32'(mem_addr), 32'd0);

        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        exp_q.push_back({8'd0, 24'h123456});
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'hAB, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        we0 = we_cnt;
        send_byte(8'hCD, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        check("midrst_nowe", 32'(we_cnt - we0), 32'd0);
        check_end("midrst", 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
